// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register driving a combinational-read instruction memory,
// one-entry output register with valid/ready handshake, redirects and an acceptance counter.
module inst_fetch #(
  parameter int unsigned               INST_WIDTH = 16,
  parameter logic [INST_WIDTH-1:0]     RESET_PC   = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [INST_WIDTH-1:0] imem_addr,
  input  logic [INST_WIDTH-1:0] imem_data,
  input  logic                  redirect_valid,
  input  logic [INST_WIDTH-1:0] redirect_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [INST_WIDTH-1:0] out_pc,
  output logic [INST_WIDTH-1:0] fetch_count
);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  localparam logic [INST_WIDTH-1:0] PcStep   = INST_WIDTH'(2);
  localparam logic [INST_WIDTH-1:0] CountMax = '1;
  // Instructions are halfword aligned, so the PC never carries bit 0.
  localparam logic [INST_WIDTH-1:0] ResetPcAligned = {RESET_PC[INST_WIDTH-1:1], 1'b0};

  state_e                  state_q, state_d;
  logic [INST_WIDTH-1:0]   pc_q, pc_d;
  logic                    out_valid_q, out_valid_d;
  logic [INST_WIDTH-1:0]   out_inst_q, out_inst_d;
  logic [INST_WIDTH-1:0]   out_pc_q, out_pc_d;
  logic [INST_WIDTH-1:0]   fetch_count_q, fetch_count_d;
  logic                    load;
  logic                    accept;

  assign imem_addr   = pc_q;
  assign out_valid   = out_valid_q;
  assign out_inst    = out_inst_q;
  assign out_pc      = out_pc_q;
  assign fetch_count = fetch_count_q;

  assign load   = (state_q == StRun) && (!out_valid_q || out_ready);
  assign accept = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;

    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StBoot;
    endcase

    // A redirect wins over a normal fetch and squashes whatever is held.
    if (redirect_valid) begin
      pc_d        = {redirect_addr[INST_WIDTH-1:1], 1'b0};
      out_valid_d = 1'b0;
      state_d     = StRun;
    end else if (load) begin
      out_inst_d  = imem_data;
      out_pc_d    = pc_q;
      out_valid_d = 1'b1;
      pc_d        = pc_q + PcStep;
    end
  end

  // An instruction handed over on a redirect edge still counts as accepted.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (accept && (fetch_count_q != CountMax)) begin
      fetch_count_d = fetch_count_q + INST_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      pc_q          <= ResetPcAligned;
      out_valid_q   <= 1'b0;
      out_inst_q    <= '0;
      out_pc_q      <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_valid_q   <= out_valid_d;
      out_inst_q    <= out_inst_d;
      out_pc_q      <= out_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch: boot latency, streaming, stall,
// redirects, PC wrap, counter saturation and asynchronous reset.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_inst;
  logic [15:0] out_pc;
  logic [15:0] fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  inst_fetch #(
    .INST_WIDTH (16),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: word0 = 2188, address 10 holds the all-zero word.
  function automatic logic [15:0] memf(input logic [15:0] a);
    if (a == 16'h0000) return 16'h2188;
    if (a == 16'h000A) return 16'h0000;
    return a ^ 16'h5A00;
  endfunction

  assign imem_data = memf(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = 16'h0000;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_inst", 32'(out_inst), 32'h0);
    check_eq("rst_pc", 32'(out_pc), 32'h0);
    check_eq("rst_count", 32'(fetch_count), 32'h0);
    check_eq("rst_addr", 32'(imem_addr), 32'h0);
    rst_n = 1'b1;

    // Boot cycle: no fetch yet
    tick();
    check_eq("boot_valid", 32'(out_valid), 32'd0);
    check_eq("boot_addr", 32'(imem_addr), 32'h0);

    // First instruction on the second edge
    tick();
    check_eq("first_valid", 32'(out_valid), 32'd1);
    check_eq("first_inst", 32'(out_inst), 32'h2188);
    check_eq("first_pc", 32'(out_pc), 32'h0);
    check_eq("first_addr", 32'(imem_addr), 32'h2);

    // Streaming with out_ready high; address 10 carries the zero word
    for (int i = 1; i < 10; i++) begin
      tick();
      check_eq("stream_valid", 32'(out_valid), 32'd1);
      check_eq("stream_pc", 32'(out_pc), 32'(2 * i));
      check_eq("stream_inst", 32'(out_inst), 32'(memf(16'(2 * i))));
      check_eq("stream_count", 32'(fetch_count), 32'(i));
    end
    tick();
    check_eq("stream_count10", 32'(fetch_count), 32'd10);
    check_eq("stream_pc20", 32'(out_pc), 32'd20);

    // Stall for three cycles: everything holds
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_pc", 32'(out_pc), 32'd20);
      check_eq("stall_inst", 32'(out_inst), 32'(memf(16'd20)));
      check_eq("stall_addr", 32'(imem_addr), 32'd22);
      check_eq("stall_count", 32'(fetch_count), 32'd10);
      check_eq("stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    check_eq("release_pc", 32'(out_pc), 32'd22);
    check_eq("release_count", 32'(fetch_count), 32'd11);

    // Redirect to odd address 9 while stalled: held instruction discarded
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = 16'h0009;
    tick();
    check_eq("redir_valid", 32'(out_valid), 32'd0);
    check_eq("redir_addr", 32'(imem_addr), 32'h8);
    check_eq("redir_count", 32'(fetch_count), 32'd11);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    tick();
    check_eq("redir_tgt_valid", 32'(out_valid), 32'd1);
    check_eq("redir_tgt_pc", 32'(out_pc), 32'h8);
    check_eq("redir_tgt_inst", 32'(out_inst), 32'(memf(16'h8)));
    check_eq("redir_tgt_count", 32'(fetch_count), 32'd11);
    tick();
    check_eq("zero_word_valid", 32'(out_valid), 32'd1);
    check_eq("zero_word_inst", 32'(out_inst), 32'h0);
    check_eq("zero_word_pc", 32'(out_pc), 32'hA);
    check_eq("zero_word_count", 32'(fetch_count), 32'd12);

    // Redirect to FFFE while an instruction is accepted on the same edge
    redirect_valid = 1'b1;
    redirect_addr  = 16'hFFFE;
    tick();
    check_eq("wrap_redir_count", 32'(fetch_count), 32'd13);
    check_eq("wrap_redir_valid", 32'(out_valid), 32'd0);
    check_eq("wrap_redir_addr", 32'(imem_addr), 32'hFFFE);
    redirect_valid = 1'b0;
    tick();
    check_eq("wrap_pc_fffe", 32'(out_pc), 32'hFFFE);
    check_eq("wrap_inst_fffe", 32'(out_inst), 32'(memf(16'hFFFE)));
    check_eq("wrap_addr0", 32'(imem_addr), 32'h0);
    tick();
    check_eq("wrap_pc_0000", 32'(out_pc), 32'h0);
    check_eq("wrap_inst_0000", 32'(out_inst), 32'h2188);
    check_eq("wrap_count", 32'(fetch_count), 32'd14);

    // Counter saturation
    force dut.fetch_count_q = 16'hFFFE;
    #1;
    release dut.fetch_count_q;
    check_eq("sat_preload", 32'(fetch_count), 32'hFFFE);
    tick();
    check_eq("sat_ffff", 32'(fetch_count), 32'hFFFF);
    tick();
    check_eq("sat_hold", 32'(fetch_count), 32'hFFFF);
    tick();
    check_eq("sat_hold2", 32'(fetch_count), 32'hFFFF);

    // Asynchronous reset mid-stream, checked before the next rising edge
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(out_valid), 32'd0);
    check_eq("arst_inst", 32'(out_inst), 32'h0);
    check_eq("arst_pc", 32'(out_pc), 32'h0);
    check_eq("arst_count", 32'(fetch_count), 32'h0);
    check_eq("arst_addr", 32'(imem_addr), 32'h0);

    // Redirect during the boot cycle goes straight to the target
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_addr  = 16'h0031;
    rst_n          = 1'b1;
    tick();
    check_eq("boot_redir_valid", 32'(out_valid), 32'd0);
    check_eq("boot_redir_addr", 32'(imem_addr), 32'h30);
    redirect_valid = 1'b0;
    tick();
    check_eq("boot_redir_fetch", 32'(out_valid), 32'd1);
    check_eq("boot_redir_pc", 32'(out_pc), 32'h30);
    check_eq("boot_redir_inst", 32'(out_inst), 32'(memf(16'h30)));
    check_eq("boot_redir_count", 32'(fetch_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
- REQ-001: Parameter INST_WIDTH, default 16; instruction and address width.
- REQ-002: Parameter RESET_PC, default 16'h0000; first fetch byte address after reset.
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: rst_n  input  1  reset is asynchronous and active-low.
- REQ-005: imem_addr  output  16  byte address to instruction memory (combinational-read memory, word index = addr>>1).
- REQ-006: imem_data  input  16  instruction word returned combinationally for imem_addr.
- REQ-007: redirect_valid  input  1  branch-taken redirect request from the execute stage.
- REQ-008: redirect_addr  input  16  redirect target byte address.
- REQ-009: out_valid  output  1  out_inst/out_pc hold a valid fetched instruction.
- REQ-010: out_ready  input  1  downstream decode accepts the instruction this cycle.
- REQ-011: out_inst  output  16  registered instruction word.
- REQ-012: out_pc  output  16  byte address out_inst was fetched from.
- REQ-013: fetch_count  output  16  number of instructions accepted downstream, saturating.

Function
- REQ-014: The block SHALL hold a PC register and drive imem_addr = PC combinationally, with no added latency.
- REQ-015: The block SHALL implement two states: BOOT (one cycle after reset release, no fetch) and RUN; BOOT SHALL go to RUN unconditionally on the next edge.
- REQ-016: In RUN, load = !out_valid || out_ready.
- REQ-017: When load is asserted and redirect_valid is not, the block SHALL register out_inst <= imem_data, out_pc <= PC and out_valid <= 1 on the edge, and SHALL set PC <= PC + 2.
- REQ-018: When out_valid = 1 and out_ready = 0, out_inst, out_pc, out_valid and PC SHALL hold unchanged.
- REQ-019: redirect_valid SHALL take priority over load in any state.
- REQ-020: On a redirect, the block SHALL set PC <= {redirect_addr[15:1], 1'b0} and out_valid <= 0 on the same edge, and SHALL fetch from the target on the following cycle.
- REQ-021: A redirect during BOOT SHALL also move the state to RUN.
- REQ-022: A redirect SHALL discard any instruction held with out_ready = 0.
- REQ-023: An instruction with out_valid = 1 and out_ready = 1 on the redirect edge SHALL count as accepted.
- REQ-024: PC arithmetic SHALL be 16-bit modulo; 16'hFFFE + 2 SHALL wrap to 16'h0000.
- REQ-025: PC bit 0 SHALL always be 0.
- REQ-026: fetch_count SHALL increment by 1 on each edge where out_valid && out_ready, and SHALL saturate at 16'hFFFF.
- REQ-027: A redirect SHALL NOT alter fetch_count.
- REQ-028: The all-zero instruction word SHALL be passed through as a normal instruction, with no special handling.

Reset
- REQ-029: While rst_n = 0, regardless of clk, the block SHALL force: state = BOOT, PC = RESET_PC, out_valid = 0, out_inst = 16'h0000, out_pc = 16'h0000, fetch_count = 16'h0000.
- REQ-030: Reset asserted mid-stall or mid-redirect SHALL abandon all in-flight state.
- REQ-031: The first valid instruction after reset SHALL appear on out_* on the second rising edge after rst_n deasserts, with out_pc = RESET_PC.

Verification
- REQ-032: Reset release, out_ready = 1, memory word0 = 16'h2188 -> edge 1: out_valid = 0 and imem_addr = 0; edge 2: out_valid = 1, out_inst = 16'h2188, out_pc = 0, imem_addr = 2.
- REQ-033: Streaming 10 words with out_ready = 1 -> out_pc sequence 0, 2, ..., 18 on consecutive cycles; fetch_count = 10 after the last acceptance.
- REQ-034: Hold out_ready = 0 for 3 cycles while out_pc = 4 -> out_inst/out_pc stable and imem_addr = 6; on release, the next out_pc = 6, with no skipped or duplicated address.
- REQ-035: redirect_valid = 1 with redirect_addr = 16'h0009 while out_pc = 14 is stalled -> next cycle out_valid = 0 and imem_addr = 8; following cycle out_pc = 8; fetch_count unchanged.
- REQ-036: Redirect to 16'hFFFE, out_ready = 1 -> out_pc = FFFE, then 0000.
- REQ-037: Force fetch_count to FFFF, then accept again -> fetch_count stays FFFF.
- REQ-038: Assert rst_n = 0 asynchronously mid-stream -> all outputs reach reset values before the next clk edge.
